// File: rtl/csa_share_arb.sv
// Shares one registered carry-save adder among NREQ requesters with round-robin grant (CSA_ARB_FIXED_PRIO_EN selects fixed lowest-index priority).
// Latency: grant in cycle 0, resp_valid from cycle ADD_LAT+2; one operation per ADD_LAT+3 cycles with resp_ready held high.
// Backpressure: while resp_ready is low the result is held and no request is granted; req_ready is low outside IDLE.
module csa_share_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [8*NREQ-1:0] req_z,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic [7:0]        add_z,
  input  logic [7:0]        add_sum,
  input  logic              add_cout,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [7:0]        resp_sum,
  output logic              resp_cout,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state;
  logic [2:0]     lat_cnt;
  logic           win_vld;
  logic [IDW-1:0] win_id;
`ifndef CSA_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] rr_ptr;
`endif

  // Pick the winner: first valid requester at or after the search start, wrapping at NREQ-1.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef CSA_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(rr_ptr) + k) % NREQ;
`endif
      if (!win_vld && ((req_valid >> idx) & NREQ'(1)) != '0) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // Grant only in IDLE and never while reset is asserted, so outputs read 0 during reset.
  always_comb begin
    req_ready = '0;
    if (rst && state == S_IDLE && win_vld)
      req_ready = NREQ'(1) << win_id;
  end

  assign busy = (state != S_IDLE);

  // Sequencer: capture operands at grant, wait out the adder latency, then hold the result until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_z      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
`ifndef CSA_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            add_a   <= 8'(req_a >> {win_id, 3'b000});
            add_b   <= 8'(req_b >> {win_id, 3'b000});
            add_z   <= 8'(req_z >> {win_id, 3'b000});
            resp_id <= win_id;
            lat_cnt <= 3'(ADD_LAT);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The adder output is valid once the countdown has run out.
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
            resp_sum   <= add_sum;
            resp_cout  <= add_cout;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
`ifndef CSA_ARB_FIXED_PRIO_EN
            rr_ptr     <= IDW'((int'(resp_id) + 1) % NREQ);
`endif
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
